word_deserializer_8: RTL and testbench

- Receive end of the 8-operand datapath: accepts one WIDTH-bit word per handshake and gathers eight consecutive words into parallel lanes a..h.
- Presents all eight lanes together with a valid/ready handshake.
- Feeds the existing 8-input combinational operand blocks from a narrow serial stream.

---
 rtl/word_deserializer_8.sv | 130 +++++++++++++
 tb/tb_word_deserializer_8.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/word_deserializer_8.sv
// Gathers eight consecutive WIDTH-bit words into parallel lanes a..h behind a valid/ready handshake.
// Optional WORD_DESERIALIZER_AND_EN adds q_and, a running bitwise AND of the lanes.
module word_deserializer_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_flush,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef WORD_DESERIALIZER_AND_EN
    output logic [WIDTH-1:0] q_and,
`endif
    output logic [3:0]       fill_cnt
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       cnt;
    logic [2:0]       cnt_next;
    logic             wr_en;
    logic [2:0]       wr_idx;
    logic [WIDTH-1:0] lane [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // In HOLD a consumer handshake may coincide with the first word of the next group.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_en      = 1'b0;
        wr_idx     = cnt;
        in_ready   = 1'b0;
        case (state)
            FILL: begin
                in_ready = rst_n;
                if (in_flush) begin
                    cnt_next = 3'd0;
                end else if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt == 3'd7) begin
                        cnt_next   = 3'd0;
                        state_next = HOLD;
                    end else begin
                        cnt_next = cnt + 3'd1;
                    end
                end
            end
            HOLD: begin
                in_ready = rst_n & out_ready;
                if (out_ready) begin
                    state_next = FILL;
                    cnt_next   = 3'd0;
                    if (in_valid) begin
                        wr_en    = 1'b1;
                        wr_idx   = 3'd0;
                        cnt_next = 3'd1;
                    end
                end
            end
            default: begin
                state_next = FILL;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                lane[i] <= '0;
            end
        end else if (wr_en) begin
            lane[wr_idx] <= in_data;
        end
    end

`ifdef WORD_DESERIALIZER_AND_EN
    logic [WIDTH-1:0] acc;

    // The first word of a group reloads the accumulator so no stale bits leak across groups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '1;
        end else if (state == FILL && in_flush) begin
            acc <= '1;
        end else if (wr_en) begin
            acc <= (wr_idx == 3'd0) ? in_data : (acc & in_data);
        end
    end

    assign q_and = acc;
`endif

    assign a         = lane[0];
    assign b         = lane[1];
    assign c         = lane[2];
    assign d         = lane[3];
    assign e         = lane[4];
    assign f         = lane[5];
    assign g         = lane[6];
    assign h         = lane[7];
    assign out_valid = (state == HOLD);
    assign fill_cnt  = {1'b0, cnt};

endmodule

// File: tb/tb_word_deserializer_8.sv
// Self-checking bench for word_deserializer_8: directed scenarios plus random traffic
// checked against a queue-based group model.
module tb_word_deserializer_8;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_flush;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       fill_cnt;
`ifdef WORD_DESERIALIZER_AND_EN
    logic [WIDTH-1:0] q_and;
`endif

    int compares = 0;
    int fails    = 0;

    // Model: accepted words of the partial group, the last completed group, and HOLD flag.
    logic [WIDTH-1:0] grp[$];
    logic [WIDTH-1:0] exp_group[8];
    bit               exp_hold;

    word_deserializer_8 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flush  (in_flush),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .h         (h),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef WORD_DESERIALIZER_AND_EN
        .q_and     (q_and),
`endif
        .fill_cnt  (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] obsLane(input int idx);
        case (idx)
            0: return a;
            1: return b;
            2: return c;
            3: return d;
            4: return e;
            5: return f;
            6: return g;
            default: return h;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [WIDTH-1:0] exp_and;
        checkOutput({tag, ":out_valid"}, 32'(out_valid), 32'(exp_hold));
        checkOutput({tag, ":fill_cnt"}, 32'(fill_cnt), 32'(grp.size()));
        if (exp_hold) begin
            exp_and = '1;
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("%s:lane%0d", tag, i), 32'(obsLane(i)), 32'(exp_group[i]));
                exp_and &= exp_group[i];
            end
`ifdef WORD_DESERIALIZER_AND_EN
            checkOutput({tag, ":q_and"}, 32'(q_and), 32'(exp_and));
`endif
        end
    endtask

    // One clock of stimulus: drive at negedge, check ready, update model at posedge, check at next negedge.
    task automatic applyStimulus(input string tag, input bit v, input logic [WIDTH-1:0] dat,
                                 input bit fl, input bit ordy);
        bit exp_ready;
        in_valid  = v;
        in_data   = dat;
        in_flush  = fl;
        out_ready = ordy;
        #1;
        exp_ready = exp_hold ? ordy : 1'b1;
        checkOutput({tag, ":in_ready"}, 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (!exp_hold) begin
            if (fl) begin
                grp.delete();
            end else if (v) begin
                grp.push_back(dat);
                if (grp.size() == 8) begin
                    for (int i = 0; i < 8; i++) exp_group[i] = grp[i];
                    grp.delete();
                    exp_hold = 1'b1;
                end
            end
        end else if (ordy) begin
            exp_hold = 1'b0;
            if (v) grp.push_back(dat);
        end
        @(negedge clk);
        checkModel(tag);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ":out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ":fill_cnt"}, 32'(fill_cnt), 32'd0);
        checkOutput({tag, ":in_ready"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("%s:lane%0d", tag, i), 32'(obsLane(i)), 32'd0);
`ifdef WORD_DESERIALIZER_AND_EN
        checkOutput({tag, ":q_and"}, 32'(q_and), 32'hFF);
`endif
    endtask

    task automatic modelReset();
        grp.delete();
        exp_hold = 1'b0;
        for (int i = 0; i < 8; i++) exp_group[i] = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_flush  = 1'b0;
        out_ready = 1'b0;
        modelReset();
        #2;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_release", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Fill 1..8 with consumer stalled, then hold for 5 cycles.
        for (int i = 1; i <= 8; i++) applyStimulus("fill1", 1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("fill1:a_const", 32'(a), 32'd1);
        checkOutput("fill1:h_const", 32'(h), 32'd8);
        for (int i = 0; i < 5; i++) applyStimulus("stall", 1'b1, 8'($urandom), 1'b0, 1'b0);
        applyStimulus("release1", 1'b0, 8'h00, 1'b0, 1'b1);

        // Back-to-back stream: second group starts on the handshake cycle.
        for (int i = 8'h10; i <= 8'h1F; i++) applyStimulus("stream", 1'b1, 8'(i), 1'b0, 1'b1);
        checkOutput("stream:a_const", 32'(a), 32'h18);
        checkOutput("stream:h_const", 32'(h), 32'h1F);
        applyStimulus("release2", 1'b0, 8'h00, 1'b0, 1'b1);

        // Flush a partial group; the word alongside the flush is dropped.
        applyStimulus("pre_flush", 1'b1, 8'hAA, 1'b0, 1'b0);
        applyStimulus("pre_flush", 1'b1, 8'hBB, 1'b0, 1'b0);
        applyStimulus("pre_flush", 1'b1, 8'hCC, 1'b0, 1'b0);
        checkOutput("pre_flush:cnt3", 32'(fill_cnt), 32'd3);
        applyStimulus("flush", 1'b1, 8'hDD, 1'b1, 1'b0);
        checkOutput("flush:cnt0", 32'(fill_cnt), 32'd0);
        for (int i = 1; i <= 8; i++) applyStimulus("post_flush", 1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("post_flush:a_const", 32'(a), 32'd1);

        // Flush in HOLD is ignored; then release without a new word.
        applyStimulus("hold_flush", 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus("hold_release", 1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-group.
        for (int i = 0; i < 5; i++) applyStimulus("pre_reset", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus("after_reset", 1'b1, 8'(8'hFF - i), 1'b0, 1'b0);
        checkOutput("after_reset:h_const", 32'(h), 32'hF8);
        applyStimulus("release3", 1'b0, 8'h00, 1'b0, 1'b1);

`ifdef WORD_DESERIALIZER_AND_EN
        for (int i = 0; i < 8; i++) applyStimulus("and01", 1'b1, 8'h01, 1'b0, 1'b0);
        checkOutput("and01:const", 32'(q_and), 32'h01);
        applyStimulus("and_rel", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus("and0f", 1'b1, (i == 7) ? 8'h0F : 8'hFF, 1'b0, 1'b0);
        checkOutput("and0f:const", 32'(q_and), 32'h0F);
        applyStimulus("and_rel", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus("and00", 1'b1, (i == 3) ? 8'h00 : 8'hFF, 1'b0, 1'b0);
        checkOutput("and00:const", 32'(q_and), 32'h00);
        applyStimulus("and_rel", 1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random", $urandom_range(0, 3) != 0, 8'($urandom),
                          $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
